ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) from the FPGA to the keyboard over the shared ps2c/ps2d lines. It sits beside the keyboard receiver in the top level. The CPU starts a send by writing a byte to a memory-mapped register decoded in the top level, and it polls `busy`/`err` through the read multiplexer. The block drives both lines open-drain and reports completion, device acknowledge, or timeout.

## Interface
- `INHIBIT_CYCLES`, default 5000: clocks that ps2c is held low before the start bit (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000: maximum clocks allowed between filtered ps2c falling edges, and in WAIT_IDLE (15 ms).
- `FILTER_LEN`, default 8: consecutive equal synchronized samples needed to accept a new ps2c level.
- `clk`  in  1: system clock. One clock domain only.
- `rst`  in  1: reset, asynchronous, active-high.
- `din`  in  8: command byte, captured when `wr` is accepted.
- `wr`  in  1: start strobe, one cycle. Ignored while `busy`=1.
- `ps2c_in`  in  1: raw PS/2 clock pin level.
- `ps2d_in`  in  1: raw PS/2 data pin level.
- `ps2c_oe`  out  1: 1 pulls ps2c low; 0 releases it (high-Z).
- `ps2d_oe`  out  1: 1 pulls ps2d low; 0 releases it (high-Z).
- `busy`  out  1: high from the cycle after `wr` is accepted until the cycle `done` pulses. The top level gates the receiver's frame capture with it.
- `done`  out  1: one-cycle pulse at the end of every transfer.
- `err`  out  1: sticky failure flag, valid when `done` pulses. 1 means NACK or timeout. Cleared when the next `wr` is accepted.

## Operation
- Input conditioning: `ps2c_in` and `ps2d_in` each pass through a 2-FF synchronizer.
  - ps2c is then filtered: `ps2c_f` changes only after FILTER_LEN equal consecutive samples.
  - `fall` is a one-cycle pulse on a 1→0 transition of `ps2c_f`.
- Parity is odd: parity bit = ~^din.
- Shift register: a 10-bit frame {stop=1, parity, din[7:0]} is shifted out LSB first.
- State machine:
  - IDLE: both `oe`=0. On `wr`, latch the frame, clear `err`, set `busy`, go to INHIBIT.
  - INHIBIT: `ps2c_oe`=1 for INHIBIT_CYCLES clocks. On the last cycle, set `ps2d_oe`=1 (start bit 0) and go to RELEASE.
  - RELEASE: `ps2c_oe`=0 and `ps2d_oe` stays 1. Clear the watchdog and go to SEND.
  - SEND: on each `fall`, drive the next frame bit with `ps2d_oe` = ~bit, and count.
    - Falls 1–8 drive din[0..7]. Fall 9 drives parity. Fall 10 drives stop (`ps2d_oe`=0).
    - After fall 10, go to ACK.
  - ACK: on the next `fall`, sample synchronized ps2d. A 0 is an acknowledge; a 1 sets `err`. Then go to WAIT_IDLE.
  - WAIT_IDLE: wait until `ps2c_f`=1 and synchronized ps2d=1. Then pulse `done`, clear `busy`, go to IDLE.
- Watchdog: a counter of width $clog2(TIMEOUT_CYCLES+1).
  - It resets on every `fall` and on every state entry.
  - In RELEASE, SEND, ACK or WAIT_IDLE, reaching TIMEOUT_CYCLES does the following: set `err`, force both `oe`=0, pulse `done`, clear `busy`, go to IDLE.
- Simultaneous events: if a timeout and a `fall` occur in the same cycle, the `fall` wins and the watchdog restarts.
- `wr` asserted in the same cycle as `done` is ignored.
- Reset, including mid-transfer, takes effect immediately:
  - state IDLE, `ps2c_oe`=0, `ps2d_oe`=0, `busy`=0, `done`=0, `err`=0;
  - counters and the shift register cleared.
  - Both lines are therefore released asynchronously.

## Timing
- `wr` accepted at edge N: `busy`=1 and `ps2c_oe`=1 from N+1.
- `ps2c_oe` stays high for exactly INHIBIT_CYCLES cycles.
- `ps2d_oe` rises in the last inhibit cycle.
- `ps2c_oe` falls in the cycle after that.
- Pin falling edge to `fall` pulse: 2 (sync) + FILTER_LEN cycles.
- Each data-line update is registered one cycle after `fall`, while ps2c is still low, so the device samples a stable bit on the following rising edge.
- `done` pulses 1 cycle after both lines are seen high in WAIT_IDLE. `busy` drops in the same cycle.
- Outputs are registered and glitch-free. `oe` never toggles while `ps2c_f`=1, except on INHIBIT entry/exit and on timeout/reset release.

## Test plan
Bench parameters: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200, FILTER_LEN=4. Each case uses a device model with a 40-cycle clock period.

- **Reset state:** hold `rst`=1 → `ps2c_oe`=0, `ps2d_oe`=0, `busy`=0, `done`=0, `err`=0. `wr` pulsed during reset has no effect.
- **Send 0xED, device ACKs:**
  - ps2c held low for exactly 20 cycles.
  - The model samples bits 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
  - The model drives the ack low → `done` pulses once, `err`=0, `busy` low after the lines return high.
- **Send 0xF4, device NACKs:** model samples parity 0 and stop 1, then leaves data high on the 11th fall → `done` pulses with `err`=1.
- **Timeout:** send 0x00 with a mute device (no clock after release) → 200 cycles after release, `err`=1, `done` pulses, both `oe`=0.
- **Busy/collision:** pulse `wr` with 0x55 during SEND of 0xED → ignored; the frame bits remain those of 0xED. A 3-cycle glitch on ps2c produces no `fall`.
- **Mid-transfer reset:** assert `rst` after fall 4 of 0xED → both `oe`=0 the same cycle. A subsequent 0xF4 send completes normally with `err`=0.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, sends one framed byte
// as the keyboard clocks it, then collects the device acknowledge or times out.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       wr,
   input  logic       ps2c_in,
   input  logic       ps2d_in,
   output logic       ps2c_oe,
   output logic       ps2d_oe,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int FLT_W = $clog2(FILTER_LEN + 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, RELEASE, SEND, ACK, WAIT_IDLE} state_t;

   logic             c_meta, c_sync, d_meta, d_sync;
   logic             ps2c_f, fall;
   logic [FLT_W-1:0] flt_cnt;

   state_t           state, state_n;
   logic             ps2c_oe_n, ps2d_oe_n, busy_n, done_n, err_n;
   logic [9:0]       shift, shift_n;
   logic [3:0]       bit_cnt, bit_cnt_n;
   logic [INH_W-1:0] inh_cnt, inh_cnt_n;
   logic [WD_W-1:0]  wd_cnt, wd_cnt_n;
   logic             watched, timeout;

   // Idle bus level is high, so the synchronizers and filter come out of reset released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_meta  <= 1'b1;
         c_sync  <= 1'b1;
         d_meta  <= 1'b1;
         d_sync  <= 1'b1;
         ps2c_f  <= 1'b1;
         flt_cnt <= '0;
         fall    <= 1'b0;
      end else begin
         c_meta <= ps2c_in;
         c_sync <= c_meta;
         d_meta <= ps2d_in;
         d_sync <= d_meta;
         fall   <= 1'b0;
         if (c_sync == ps2c_f) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
            ps2c_f  <= c_sync;
            flt_cnt <= '0;
            fall    <= ps2c_f;
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ps2c_oe <= 1'b0;
         ps2d_oe <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         shift   <= '0;
         bit_cnt <= '0;
         inh_cnt <= '0;
         wd_cnt  <= '0;
      end else begin
         state   <= state_n;
         ps2c_oe <= ps2c_oe_n;
         ps2d_oe <= ps2d_oe_n;
         busy    <= busy_n;
         done    <= done_n;
         err     <= err_n;
         shift   <= shift_n;
         bit_cnt <= bit_cnt_n;
         inh_cnt <= inh_cnt_n;
         wd_cnt  <= wd_cnt_n;
      end
   end

   // A fall in the same cycle as an expiring watchdog restarts it instead of timing out.
   assign watched = (state == RELEASE) || (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
   assign timeout = watched && !fall && (wd_cnt == WD_W'(TIMEOUT_CYCLES));

   always_comb begin
      state_n   = state;
      ps2c_oe_n = ps2c_oe;
      ps2d_oe_n = ps2d_oe;
      busy_n    = busy;
      done_n    = 1'b0;
      err_n     = err;
      shift_n   = shift;
      bit_cnt_n = bit_cnt;
      inh_cnt_n = inh_cnt;
      wd_cnt_n  = '0;
      if (watched && !fall && !timeout) wd_cnt_n = wd_cnt + 1'b1;

      case (state)
         IDLE: begin
            ps2c_oe_n = 1'b0;
            ps2d_oe_n = 1'b0;
            if (wr && !done) begin
               shift_n   = {1'b1, ~^din, din};
               err_n     = 1'b0;
               busy_n    = 1'b1;
               ps2c_oe_n = 1'b1;
               if (INHIBIT_CYCLES < 2) ps2d_oe_n = 1'b1;
               inh_cnt_n = '0;
               bit_cnt_n = '0;
               state_n   = INHIBIT;
            end
         end
         INHIBIT: begin
            inh_cnt_n = inh_cnt + 1'b1;
            if (inh_cnt == INH_W'(INHIBIT_CYCLES - 2)) ps2d_oe_n = 1'b1;
            if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
               ps2c_oe_n = 1'b0;
               ps2d_oe_n = 1'b1;
               state_n   = RELEASE;
            end
         end
         RELEASE: begin
            ps2c_oe_n = 1'b0;
            state_n   = SEND;
         end
         SEND: begin
            if (fall) begin
               ps2d_oe_n = ~shift[0];
               shift_n   = {1'b0, shift[9:1]};
               bit_cnt_n = bit_cnt + 1'b1;
               if (bit_cnt == 4'd9) state_n = ACK;
            end
         end
         ACK: begin
            if (fall) begin
               err_n   = d_sync;
               state_n = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (ps2c_f && d_sync) begin
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      if (timeout) begin
         err_n     = 1'b1;
         ps2c_oe_n = 1'b0;
         ps2d_oe_n = 1'b0;
         done_n    = 1'b1;
         busy_n    = 1'b0;
         state_n   = IDLE;
      end

      if (state_n != state) wd_cnt_n = '0;
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized scoreboard bench for ps2_host_tx: a keyboard model clocks the frame out,
// expected outcomes are queued at issue time and a monitor checks them at each done.
module tb_ps2_host_tx;

   localparam int INH  = 20;
   localparam int TO   = 200;
   localparam int FL   = 4;
   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr;
   logic [7:0] din;
   logic       ps2c_in, ps2d_in;
   logic       ps2c_oe, ps2d_oe, busy, done, err;
   logic       dev_c_low = 1'b0;
   logic       dev_d_low = 1'b0;

   typedef struct {
      logic [7:0] data;
      logic       exp_err;
      logic       check_frame;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [9:0] dev_frame = '0;
   int         checks = 0;
   int         failures = 0;
   int         done_seen = 0;
   logic       prev_done = 1'b0;

   // Open-drain bus: a line is low whenever either side pulls it.
   assign ps2c_in = ~(ps2c_oe | dev_c_low);
   assign ps2d_in = ~(ps2d_oe | dev_d_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TO),
      .FILTER_LEN(FL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .din(din),
      .wr(wr),
      .ps2c_in(ps2c_in),
      .ps2d_in(ps2d_in),
      .ps2c_oe(ps2c_oe),
      .ps2d_oe(ps2d_oe),
      .busy(busy),
      .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Frame as the keyboard should see it: data LSB first, odd parity, stop bit 1.
   function automatic logic [9:0] refFrame(input logic [7:0] d);
      int ones;
      ones = $countones(d);
      return 10'(d) + (((ones % 2) == 0) ? 10'd256 : 10'd0) + 10'd512;
   endfunction

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_seen++;
         checkOutput("done_single_pulse", 32'(prev_done), 32'd0);
         checkOutput("busy_at_done", 32'(busy), 32'd0);
         checkOutput("ps2c_oe_at_done", 32'(ps2c_oe), 32'd0);
         checkOutput("ps2d_oe_at_done", 32'(ps2d_oe), 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_done: got done=1 expected no pulse at %0t", $time);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("err_at_done", 32'(err), 32'(mon_e.exp_err));
            if (mon_e.check_frame)
               checkOutput("frame_bits", 32'(dev_frame), 32'(refFrame(mon_e.data)));
         end
      end
      prev_done = done;
   end

   // mode 0: normal, 1: collision wr + ps2c glitch, 2: mute device, 3: reset after fall 4
   task automatic applyStimulus(input logic [7:0] data, input logic ack, input int mode);
      exp_t e;
      int   cnt;
      int   start_done;
      logic d_last, d_prev;
      e.data        = data;
      e.exp_err     = (mode == 2) ? 1'b1 : ~ack;
      e.check_frame = (mode != 2);
      dev_frame     = '0;
      @(negedge clk);
      din = data;
      wr  = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      wr  = 1'b0;
      din = 8'($urandom);
      checkOutput("busy_after_wr", 32'(busy), 32'd1);
      checkOutput("ps2c_oe_after_wr", 32'(ps2c_oe), 32'd1);
      cnt    = 0;
      d_last = 1'b0;
      d_prev = 1'b0;
      while (ps2c_oe === 1'b1 && cnt < 1000) begin
         d_prev = d_last;
         d_last = ps2d_oe;
         cnt++;
         @(negedge clk);
      end
      checkOutput("inhibit_len", 32'(cnt), 32'(INH));
      checkOutput("ps2d_oe_last_inhibit", 32'(d_last), 32'd1);
      checkOutput("ps2d_oe_before_last", 32'(d_prev), 32'd0);
      checkOutput("start_bit_held", 32'(ps2d_oe), 32'd1);

      if (mode == 2) begin
         cnt = 0;
         while (done !== 1'b1 && cnt < 400) begin
            @(negedge clk);
            cnt++;
         end
         checks++;
         if (cnt < TO - 2 || cnt > TO + 6) begin
            failures++;
            $display("[TB] FAIL timeout_latency: got %0d cycles expected about %0d", cnt, TO);
         end
         return;
      end

      start_done = done_seen;
      repeat (5) @(negedge clk);
      for (int i = 1; i <= 11; i++) begin
         if (i == 11 && ack) dev_d_low = 1'b1;
         dev_c_low = 1'b1;
         if (mode == 1 && i == 2) begin
            @(negedge clk);
            din = 8'h55;
            wr  = 1'b1;
            @(negedge clk);
            wr  = 1'b0;
            repeat (HALF - 2) @(negedge clk);
         end else if (mode == 3 && i == 4) begin
            repeat (12) @(negedge clk);
            #2 rst = 1'b1;
            #1;
            checkOutput("reset_busy", 32'(busy), 32'd0);
            checkOutput("reset_ps2c_oe", 32'(ps2c_oe), 32'd0);
            checkOutput("reset_ps2d_oe", 32'(ps2d_oe), 32'd0);
            dev_c_low = 1'b0;
            dev_d_low = 1'b0;
            exp_q.delete();
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            return;
         end else begin
            repeat (HALF) @(negedge clk);
         end
         if (i <= 10) dev_frame[i-1] = ps2d_in;
         dev_c_low = 1'b0;
         if (i == 11) dev_d_low = 1'b0;
         if (mode == 1 && i == 3) begin
            repeat (8) @(negedge clk);
            dev_c_low = 1'b1;
            repeat (3) @(negedge clk);
            dev_c_low = 1'b0;
            repeat (HALF - 11) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
      end
      cnt = 0;
      while (done_seen == start_done && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      if (done_seen == start_done) begin
         checks++;
         failures++;
         $display("[TB] FAIL done_missing: got no done expected one for 0x%0h", data);
      end
   endtask

   initial begin
      logic [7:0] rb;
      logic       ra;
      rst = 1'b1;
      wr  = 1'b0;
      din = 8'h00;
      repeat (3) @(negedge clk);
      din = 8'hAA;
      wr  = 1'b1;
      @(negedge clk);
      wr  = 1'b0;
      checkOutput("rst_ps2c_oe", 32'(ps2c_oe), 32'd0);
      checkOutput("rst_ps2d_oe", 32'(ps2d_oe), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("idle_busy_after_reset", 32'(busy), 32'd0);
      checkOutput("idle_ps2c_oe_after_reset", 32'(ps2c_oe), 32'd0);

      applyStimulus(8'hED, 1'b1, 0);
      repeat (10) @(negedge clk);
      applyStimulus(8'hF4, 1'b0, 0);
      repeat (10) @(negedge clk);
      applyStimulus(8'h00, 1'b1, 2);
      repeat (10) @(negedge clk);
      applyStimulus(8'hED, 1'b1, 1);
      repeat (10) @(negedge clk);
      applyStimulus(8'hED, 1'b1, 3);
      repeat (10) @(negedge clk);
      applyStimulus(8'hF4, 1'b1, 0);
      repeat (10) @(negedge clk);
      for (int n = 0; n < 5; n++) begin
         rb = 8'($urandom);
         ra = 1'($urandom_range(0, 1));
         applyStimulus(rb, ra, 0);
         repeat (10) @(negedge clk);
      end
      checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      checkOutput("idle_busy_at_end", 32'(busy), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: got no completion expected finish before limit");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
